npu_csr_slave: RTL and testbench
================================

# npu_csr_slave

AXI4-Lite responder that terminates the host CSR bus of the conv accelerator and holds its command and configuration registers. Host writes land in a command register (0x00), nine configuration registers (0x04-0x24) and a status register (0x28). A command write launches the compute engine with a one-cycle start pulse. Completion from the engine is latched into a sticky done bit that drives the interrupt line.

## Interface
- DATA_WIDTH, 32, AXI data width; only 32 is supported.
- ADDR_WIDTH, `CSR_ADDR_WIDTH`, AXI address width; only bits [5:2] are decoded, all other bits are ignored.
- NUM_CFG, 9, number of configuration registers, at offsets 0x04 to 0x04+4*(NUM_CFG-1).

Ports (name, direction, width, meaning):
- clk  in  1  the single clock; everything is rising-edge.
- rst_n  in  1  reset, synchronous, active-low.
- s00_axi_awaddr / awprot / awvalid  in  ADDR_WIDTH / 3 / 1  write address channel; awprot is ignored.
- s00_axi_awready  out  1  write address ready.
- s00_axi_wdata / wstrb / wvalid  in  32 / 4 / 1  write data channel.
- s00_axi_wready  out  1  write data ready.
- s00_axi_bresp / bvalid  out  2 / 1  write response.
- s00_axi_bready  in  1  write response ready.
- s00_axi_araddr / arprot / arvalid  in  ADDR_WIDTH / 3 / 1  read address channel; arprot is ignored.
- s00_axi_arready  out  1  read address ready.
- s00_axi_rdata / rresp / rvalid  out  32 / 2 / 1  read data channel.
- s00_axi_rready  in  1  read data ready.
- cfg_regs  out  NUM_CFG*32  configuration registers; register k (offset 0x04+4k) occupies bits [32k+31:32k].
- cmd_word  out  32  last accepted command word.
- start  out  1  one-cycle pulse that launches the engine.
- busy  out  1  engine running.
- engine_done  in  1  single-cycle completion pulse from the engine.
- irq  out  1  compute_done interrupt; equals the sticky done bit.

## Operation
- Reset (rst_n=0 at a clock edge) clears every register and output to 0, including all readies, bvalid, rvalid, busy, done, start and irq.
- Write path:
  - AW and W are captured independently, in either order or in the same cycle.
  - awready is 1 while no address is held; wready is 1 while no data is held. Each drops after its own handshake.
  - When both address and data are held and bvalid=0: commit the write, assert bvalid with bresp, and clear both holding registers.
  - awready and wready return to 1 on the cycle after the B handshake.
- Write byte strobes apply to CMD (0x00) and the configuration registers.
- CMD write (offset 0x00):
  - If busy=0: latch cmd_word, pulse start for one cycle on the commit edge, set busy, respond OKAY.
  - If busy=1: cmd_word is unchanged, no start pulse, respond SLVERR (2'b10).
- Configuration write (0x04-0x24): OKAY when busy=0. When busy=1 the write is dropped and the response is SLVERR.
- STATUS (0x28): bit0=busy (read-only), bit1=done. Writing 1 to bit1 clears done; all other bits read 0.
- Unmapped offset (0x2C-0x3C):
  - Writes have no effect and return DECERR (2'b11).
  - Reads return rdata=0 with DECERR.
- CMD reads back cmd_word.
- Read path:
  - arready=1 while rvalid=0.
  - On the AR handshake, rdata and rresp are registered from the current register values and rvalid rises on the next edge.
  - rvalid, rdata and rresp are held until rready; arready returns to 1 on the cycle after the R handshake.
- engine_done clears busy and sets done.
- Simultaneous events:
  - engine_done and a W1C of done in the same cycle: the set wins, done=1.
  - engine_done and a CMD commit in the same cycle: busy has already cleared, so the command is accepted and busy stays 1.
- Read and write to the same register in the same cycle: the read returns the pre-write value.

## Timing
- Write latency: bvalid rises one cycle after the later of the AW and W handshakes. Register outputs and start change on that same edge.
- Read latency: rvalid rises one cycle after the AR handshake. Maximum read throughput is one read every 2 cycles.
- start is high for exactly one cycle per accepted command.
- busy rises with start and falls on the cycle after engine_done.
- irq rises on the cycle after engine_done.
- After rst_n is released, the readies rise one cycle later.
- If reset is asserted mid-transaction, the pending transaction is discarded with no response issued.

## Structure
- Shared package npu_csr_pkg holds:
  - the offset constants CSR_CMD=0x00, CSR_CFG0=0x04, CSR_STATUS=0x28;
  - the response codes RESP_OKAY, RESP_SLVERR, RESP_DECERR;
  - the STATUS bit indices.
- A single module with no sub-modules; the write-side and read-side logic are separate always blocks.

## Test plan
- Write 0x42000000 to 0x40000004 with AW first and W two cycles later. Expect bresp=OKAY and a readback of 0x42000000. Repeat with W before AW, then with AW and W in the same cycle.
- Write the nine configuration registers with 0x42000000, 0x44000000, 0x64, 0x20, 0x3, 0x10, 0x44010000, 49, 9. Read all nine back and expect identical values.
- Write 0x0302FFE1 to the CMD register. Expect one start pulse and busy=1, and a CMD readback of 0x0302FFE1. Write the CMD register again while busy and expect SLVERR with cmd_word unchanged.
- Pulse engine_done. Expect busy=0 and irq=1 on the next cycle, and STATUS=0x2. Write 0x2 to STATUS and expect irq=0. Then issue engine_done and the W1C in the same cycle and expect irq to stay 1.
- Write with wstrb=4'b0010 and wdata=0xAABBCCDD to 0x0C, which holds 0x64. Expect the readback 0x0000CC64.
- Read offset 0x30 and expect rdata=0 with DECERR. Hold rready=0 for 5 cycles and expect rvalid and rdata held and arready=0. Assert reset mid-write and expect all outputs at 0.

Source files
------------

// File: rtl/npu_csr_pkg.sv
// Shared constants for the conv accelerator CSR block: register offsets,
// AXI response codes, STATUS bit positions and the byte-strobe merge helper.
package npu_csr_pkg;

  localparam int CSR_ADDR_WIDTH = 32;

  localparam logic [5:0] CSR_CMD    = 6'h00;
  localparam logic [5:0] CSR_CFG0   = 6'h04;
  localparam logic [5:0] CSR_STATUS = 6'h28;

  // Word indices as seen on address bits [5:2]
  localparam logic [3:0] IDX_CMD    = CSR_CMD[5:2];
  localparam logic [3:0] IDX_CFG0   = CSR_CFG0[5:2];
  localparam logic [3:0] IDX_STATUS = CSR_STATUS[5:2];

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  localparam int STATUS_BUSY_BIT = 0;
  localparam int STATUS_DONE_BIT = 1;

  function automatic logic [31:0] apply_wstrb(input logic [31:0] cur,
                                              input logic [31:0] data,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = cur;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = data[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/npu_csr_slave.sv
// AXI4-Lite CSR responder for the conv accelerator: command, configuration
// and status registers, start pulse generation and sticky done interrupt.
module npu_csr_slave
  import npu_csr_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = CSR_ADDR_WIDTH,
  parameter int NUM_CFG    = 9
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [ADDR_WIDTH-1:0]         s00_axi_awaddr,
  input  logic [2:0]                    s00_axi_awprot,
  input  logic                          s00_axi_awvalid,
  output logic                          s00_axi_awready,
  input  logic [DATA_WIDTH-1:0]         s00_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]       s00_axi_wstrb,
  input  logic                          s00_axi_wvalid,
  output logic                          s00_axi_wready,
  output logic [1:0]                    s00_axi_bresp,
  output logic                          s00_axi_bvalid,
  input  logic                          s00_axi_bready,
  input  logic [ADDR_WIDTH-1:0]         s00_axi_araddr,
  input  logic [2:0]                    s00_axi_arprot,
  input  logic                          s00_axi_arvalid,
  output logic                          s00_axi_arready,
  output logic [DATA_WIDTH-1:0]         s00_axi_rdata,
  output logic [1:0]                    s00_axi_rresp,
  output logic                          s00_axi_rvalid,
  input  logic                          s00_axi_rready,
  output logic [NUM_CFG*DATA_WIDTH-1:0] cfg_regs,
  output logic [DATA_WIDTH-1:0]         cmd_word,
  output logic                          start,
  output logic                          busy,
  input  logic                          engine_done,
  output logic                          irq
);

  logic                    aw_held_reg, aw_held_next;
  logic [3:0]              aw_idx_reg, aw_idx_next;
  logic                    w_held_reg, w_held_next;
  logic [DATA_WIDTH-1:0]   wdata_reg, wdata_next;
  logic [DATA_WIDTH/8-1:0] wstrb_reg, wstrb_next;
  logic                    awready_reg, awready_next;
  logic                    wready_reg, wready_next;
  logic                    bvalid_reg, bvalid_next;
  resp_e                   bresp_reg, bresp_next;
  logic [DATA_WIDTH-1:0]   cmd_word_reg, cmd_word_next;
  logic [DATA_WIDTH-1:0]   cfg_reg [NUM_CFG];
  logic [DATA_WIDTH-1:0]   cfg_next [NUM_CFG];
  logic                    busy_reg, busy_next;
  logic                    done_reg, done_next;
  logic                    start_reg, start_next;
  logic                    commit, busy_free, cfg_hit;

  logic                    arready_reg, rvalid_reg;
  logic [DATA_WIDTH-1:0]   rdata_reg, read_data, status_word;
  resp_e                   rresp_reg, read_resp;

  logic unused_inputs;
  assign unused_inputs = ^{s00_axi_awaddr, s00_axi_araddr, s00_axi_awprot, s00_axi_arprot};

  assign commit    = aw_held_reg && w_held_reg && !bvalid_reg;
  // A completion in the same cycle frees the engine for this commit
  assign busy_free = !busy_reg || engine_done;

  always_comb begin
    aw_held_next  = aw_held_reg;
    aw_idx_next   = aw_idx_reg;
    w_held_next   = w_held_reg;
    wdata_next    = wdata_reg;
    wstrb_next    = wstrb_reg;
    bvalid_next   = bvalid_reg;
    bresp_next    = bresp_reg;
    cmd_word_next = cmd_word_reg;
    cfg_next      = cfg_reg;
    busy_next     = busy_reg;
    done_next     = done_reg;
    start_next    = 1'b0;
    cfg_hit       = 1'b0;

    if (engine_done) busy_next = 1'b0;

    if (awready_reg && s00_axi_awvalid) begin
      aw_held_next = 1'b1;
      aw_idx_next  = s00_axi_awaddr[5:2];
    end
    if (wready_reg && s00_axi_wvalid) begin
      w_held_next = 1'b1;
      wdata_next  = s00_axi_wdata;
      wstrb_next  = s00_axi_wstrb;
    end
    if (bvalid_reg && s00_axi_bready) bvalid_next = 1'b0;

    if (commit) begin
      aw_held_next = 1'b0;
      w_held_next  = 1'b0;
      bvalid_next  = 1'b1;
      bresp_next   = RESP_OKAY;
      for (int k = 0; k < NUM_CFG; k++) begin
        if (aw_idx_reg == IDX_CFG0 + 4'(k)) begin
          cfg_hit = 1'b1;
          if (busy_free) cfg_next[k] = apply_wstrb(cfg_reg[k], wdata_reg, wstrb_reg);
        end
      end
      if (aw_idx_reg == IDX_CMD) begin
        if (busy_free) begin
          cmd_word_next = apply_wstrb(cmd_word_reg, wdata_reg, wstrb_reg);
          start_next    = 1'b1;
          busy_next     = 1'b1;
        end else begin
          bresp_next = RESP_SLVERR;
        end
      end else if (aw_idx_reg == IDX_STATUS) begin
        if (wdata_reg[STATUS_DONE_BIT]) done_next = 1'b0;
      end else if (cfg_hit) begin
        if (!busy_free) bresp_next = RESP_SLVERR;
      end else begin
        bresp_next = RESP_DECERR;
      end
    end

    // Completion set takes priority over a same-cycle W1C
    if (engine_done) done_next = 1'b1;

    awready_next = !aw_held_next && !bvalid_next;
    wready_next  = !w_held_next && !bvalid_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      aw_held_reg  <= 1'b0;
      aw_idx_reg   <= '0;
      w_held_reg   <= 1'b0;
      wdata_reg    <= '0;
      wstrb_reg    <= '0;
      awready_reg  <= 1'b0;
      wready_reg   <= 1'b0;
      bvalid_reg   <= 1'b0;
      bresp_reg    <= RESP_OKAY;
      cmd_word_reg <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      start_reg    <= 1'b0;
      for (int k = 0; k < NUM_CFG; k++) cfg_reg[k] <= '0;
    end else begin
      aw_held_reg  <= aw_held_next;
      aw_idx_reg   <= aw_idx_next;
      w_held_reg   <= w_held_next;
      wdata_reg    <= wdata_next;
      wstrb_reg    <= wstrb_next;
      awready_reg  <= awready_next;
      wready_reg   <= wready_next;
      bvalid_reg   <= bvalid_next;
      bresp_reg    <= bresp_next;
      cmd_word_reg <= cmd_word_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      start_reg    <= start_next;
      cfg_reg      <= cfg_next;
    end
  end

  always_comb begin
    status_word                  = '0;
    status_word[STATUS_BUSY_BIT] = busy_reg;
    status_word[STATUS_DONE_BIT] = done_reg;
  end

  always_comb begin
    read_data = '0;
    read_resp = RESP_DECERR;
    for (int k = 0; k < NUM_CFG; k++) begin
      if (s00_axi_araddr[5:2] == IDX_CFG0 + 4'(k)) begin
        read_data = cfg_reg[k];
        read_resp = RESP_OKAY;
      end
    end
    if (s00_axi_araddr[5:2] == IDX_CMD) begin
      read_data = cmd_word_reg;
      read_resp = RESP_OKAY;
    end else if (s00_axi_araddr[5:2] == IDX_STATUS) begin
      read_data = status_word;
      read_resp = RESP_OKAY;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      arready_reg <= 1'b0;
      rvalid_reg  <= 1'b0;
      rdata_reg   <= '0;
      rresp_reg   <= RESP_OKAY;
    end else if (arready_reg && s00_axi_arvalid) begin
      arready_reg <= 1'b0;
      rvalid_reg  <= 1'b1;
      rdata_reg   <= read_data;
      rresp_reg   <= read_resp;
    end else if (rvalid_reg && s00_axi_rready) begin
      arready_reg <= 1'b1;
      rvalid_reg  <= 1'b0;
    end else if (!rvalid_reg) begin
      arready_reg <= 1'b1;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_CFG; gi++) begin : g_cfg_out
      assign cfg_regs[gi*DATA_WIDTH +: DATA_WIDTH] = cfg_reg[gi];
    end
  endgenerate

  assign s00_axi_awready = awready_reg;
  assign s00_axi_wready  = wready_reg;
  assign s00_axi_bvalid  = bvalid_reg;
  assign s00_axi_bresp   = bresp_reg;
  assign s00_axi_arready = arready_reg;
  assign s00_axi_rvalid  = rvalid_reg;
  assign s00_axi_rdata   = rdata_reg;
  assign s00_axi_rresp   = rresp_reg;
  assign cmd_word        = cmd_word_reg;
  assign start           = start_reg;
  assign busy            = busy_reg;
  assign irq             = done_reg;

endmodule

// File: tb/tb_npu_csr_slave.sv
// Scoreboard bench for npu_csr_slave: stimulus queues expected B/R responses,
// a monitor pops and compares them on each handshake.
module tb_npu_csr_slave;
  import npu_csr_pkg::*;

  localparam int NUM_CFG = 9;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [31:0]         awaddr = '0;
  logic [2:0]          awprot = '0;
  logic                awvalid = 1'b0;
  logic                awready;
  logic [31:0]         wdata = '0;
  logic [3:0]          wstrb = '0;
  logic                wvalid = 1'b0;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready = 1'b1;
  logic [31:0]         araddr = '0;
  logic [2:0]          arprot = '0;
  logic                arvalid = 1'b0;
  logic                arready;
  logic [31:0]         rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready = 1'b1;
  logic [NUM_CFG*32-1:0] cfg_regs;
  logic [31:0]         cmd_word;
  logic                start, busy, irq;
  logic                engine_done = 1'b0;

  typedef struct {
    logic [1:0]  resp;
    logic [31:0] data;
    string       name;
  } exp_t;

  exp_t wq[$];
  exp_t rq[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   start_cnt = 0;

  npu_csr_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .NUM_CFG(NUM_CFG)) dut (
    .clk(clk), .rst_n(rst_n),
    .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid),
    .s00_axi_awready(awready),
    .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wvalid(wvalid),
    .s00_axi_wready(wready),
    .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
    .s00_axi_araddr(araddr), .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid),
    .s00_axi_arready(arready),
    .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid),
    .s00_axi_rready(rready),
    .cfg_regs(cfg_regs), .cmd_word(cmd_word), .start(start), .busy(busy),
    .engine_done(engine_done), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h required 0x%08h", nm, act, exp);
  endtask

  task automatic timeout(input string nm);
    n_checks++;
    $display("FAIL %s: got no DUT response within bound, required a handshake", nm);
  endtask

  // Monitor: compare every B and R handshake against the scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && bvalid && bready) begin
        if (wq.size() == 0) check("unexpected_b", 32'(bvalid), 32'h0);
        else begin
          exp_t e;
          e = wq.pop_front();
          check({e.name, "_bresp"}, {30'b0, bresp}, {30'b0, e.resp});
        end
      end
      if (rst_n && rvalid && rready) begin
        if (rq.size() == 0) check("unexpected_r", 32'(rvalid), 32'h0);
        else begin
          exp_t e;
          e = rq.pop_front();
          check({e.name, "_rresp"}, {30'b0, rresp}, {30'b0, e.resp});
          check({e.name, "_rdata"}, rdata, e.data);
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (start) start_cnt++;
    end
  end

  task automatic wait_drain(input string nm);
    int cnt;
    cnt = 0;
    while ((wq.size() != 0 || rq.size() != 0) && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    if (wq.size() != 0 || rq.size() != 0) begin
      timeout(nm);
      wq.delete();
      rq.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic send_aw(input logic [31:0] addr, input int dly);
    int cnt;
    repeat (dly) @(posedge clk);
    #1; awaddr = addr; awvalid = 1'b1;
    cnt = 0;
    @(negedge clk);
    while (!awready && cnt < 50) begin @(negedge clk); cnt++; end
    if (!awready) timeout("aw_handshake");
    @(posedge clk); #1; awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] data, input logic [3:0] strb, input int dly);
    int cnt;
    repeat (dly) @(posedge clk);
    #1; wdata = data; wstrb = strb; wvalid = 1'b1;
    cnt = 0;
    @(negedge clk);
    while (!wready && cnt < 50) begin @(negedge clk); cnt++; end
    if (!wready) timeout("w_handshake");
    @(posedge clk); #1; wvalid = 1'b0;
  endtask

  task automatic send_ar(input logic [31:0] addr);
    int cnt;
    araddr = addr; arvalid = 1'b1;
    cnt = 0;
    @(negedge clk);
    while (!arready && cnt < 50) begin @(negedge clk); cnt++; end
    if (!arready) timeout("ar_handshake");
    @(posedge clk); #1; arvalid = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, input logic [1:0] exp, input string nm);
    wq.push_back('{resp: exp, data: 32'h0, name: nm});
    fork
      send_aw(addr, aw_dly);
      send_w(data, strb, w_dly);
    join
    wait_drain(nm);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [31:0] exp_data,
                         input logic [1:0] exp, input string nm);
    rq.push_back('{resp: exp, data: exp_data, name: nm});
    send_ar(addr);
    wait_drain(nm);
  endtask

  logic [31:0] cfg_vals [NUM_CFG] = '{32'h42000000, 32'h44000000, 32'h64, 32'h20, 32'h3,
                                      32'h10, 32'h44010000, 32'd49, 32'd9};
  int s0;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_awready", 32'(awready), 0);
    check("rst_wready", 32'(wready), 0);
    check("rst_arready", 32'(arready), 0);
    check("rst_bvalid", 32'(bvalid), 0);
    check("rst_rvalid", 32'(rvalid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_irq", 32'(irq), 0);
    check("rst_start", 32'(start), 0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_release_early", 32'(awready), 0);
    @(negedge clk);
    check("ready_after_release_aw", 32'(awready), 1);
    check("ready_after_release_w", 32'(wready), 1);
    check("ready_after_release_ar", 32'(arready), 1);
    @(posedge clk); #1;

    // Channel ordering
    do_write(32'h40000004, 32'h42000000, 4'hF, 0, 2, RESP_OKAY, "aw_first");
    do_read(32'h40000004, 32'h42000000, RESP_OKAY, "aw_first_rb");
    do_write(32'h40000004, 32'h11223344, 4'hF, 2, 0, RESP_OKAY, "w_first");
    do_read(32'h40000004, 32'h11223344, RESP_OKAY, "w_first_rb");
    do_write(32'h40000004, 32'h42000000, 4'hF, 0, 0, RESP_OKAY, "aw_w_same");
    do_read(32'h40000004, 32'h42000000, RESP_OKAY, "aw_w_same_rb");

    for (int k = 0; k < NUM_CFG; k++)
      do_write(32'h40000004 + 32'(4*k), cfg_vals[k], 4'hF, 0, 0, RESP_OKAY, $sformatf("cfg%0d_w", k));
    for (int k = 0; k < NUM_CFG; k++)
      do_read(32'h40000004 + 32'(4*k), cfg_vals[k], RESP_OKAY, $sformatf("cfg%0d_rb", k));
    check("cfg8_port", cfg_regs[8*32 +: 32], 32'd9);
    check("cfg0_port", cfg_regs[0 +: 32], 32'h42000000);

    // Command launch and busy rejection
    s0 = start_cnt;
    do_write(32'h40000000, 32'h0302FFE1, 4'hF, 0, 0, RESP_OKAY, "cmd_write");
    check("cmd_start_pulses", 32'(start_cnt - s0), 1);
    @(negedge clk);
    check("cmd_busy", 32'(busy), 1);
    @(posedge clk); #1;
    do_read(32'h40000000, 32'h0302FFE1, RESP_OKAY, "cmd_rb");
    do_read(32'h40000028, 32'h1, RESP_OKAY, "status_busy");
    s0 = start_cnt;
    do_write(32'h40000000, 32'hDEADBEEF, 4'hF, 0, 0, RESP_SLVERR, "cmd_while_busy");
    check("cmd_busy_no_start", 32'(start_cnt - s0), 0);
    check("cmd_busy_word", cmd_word, 32'h0302FFE1);
    do_write(32'h40000004, 32'h12345678, 4'hF, 0, 0, RESP_SLVERR, "cfg_while_busy");
    do_read(32'h40000004, 32'h42000000, RESP_OKAY, "cfg_busy_rb");

    // Completion, W1C, and completion racing a W1C
    engine_done = 1'b1;
    @(posedge clk); #1; engine_done = 1'b0;
    @(negedge clk);
    check("done_busy_clear", 32'(busy), 0);
    check("done_irq_set", 32'(irq), 1);
    @(posedge clk); #1;
    do_read(32'h40000028, 32'h2, RESP_OKAY, "status_done");
    do_write(32'h40000028, 32'h2, 4'hF, 0, 0, RESP_OKAY, "status_w1c");
    @(negedge clk);
    check("w1c_irq_clear", 32'(irq), 0);
    @(posedge clk); #1;
    wq.push_back('{resp: RESP_OKAY, data: 32'h0, name: "w1c_vs_done"});
    awaddr = 32'h40000028; wdata = 32'h2; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(posedge clk); #1; awvalid = 1'b0; wvalid = 1'b0; engine_done = 1'b1;
    @(posedge clk); #1; engine_done = 1'b0;
    @(negedge clk);
    check("w1c_vs_done_irq", 32'(irq), 1);
    @(posedge clk); #1;
    wait_drain("w1c_vs_done");

    // Byte strobes
    do_write(32'h4000000C, 32'hAABBCCDD, 4'b0010, 0, 0, RESP_OKAY, "strobe_w");
    do_read(32'h4000000C, 32'h0000CC64, RESP_OKAY, "strobe_rb");

    // Unmapped accesses with read backpressure
    do_write(32'h40000030, 32'h55, 4'hF, 0, 0, RESP_DECERR, "unmapped_w");
    rready = 1'b0;
    rq.push_back('{resp: RESP_DECERR, data: 32'h0, name: "unmapped_r"});
    send_ar(32'h40000030);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("hold%0d_rvalid", i), 32'(rvalid), 1);
      check($sformatf("hold%0d_rdata", i), rdata, 32'h0);
      check($sformatf("hold%0d_arready", i), 32'(arready), 0);
    end
    @(posedge clk); #1; rready = 1'b1;
    wait_drain("unmapped_r");

    // Reset in the middle of a write
    do_write(32'h40000000, 32'h77, 4'hF, 0, 0, RESP_OKAY, "cmd_relaunch");
    awaddr = 32'h40000008; awvalid = 1'b1;
    @(posedge clk); #1; awvalid = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("midrst_awready", 32'(awready), 0);
    check("midrst_wready", 32'(wready), 0);
    check("midrst_arready", 32'(arready), 0);
    check("midrst_bvalid", 32'(bvalid), 0);
    check("midrst_rvalid", 32'(rvalid), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_irq", 32'(irq), 0);
    check("midrst_start", 32'(start), 0);
    check("midrst_cmd_word", cmd_word, 32'h0);
    check("midrst_cfg_any", 32'(|cfg_regs), 0);
    check("midrst_rdata", rdata, 32'h0);
    @(posedge clk); #1; rst_n = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("post_rst_no_b", 32'(bvalid), 0);
    check("pending_w_exp", 32'(wq.size()), 0);
    check("pending_r_exp", 32'(rq.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
